// File: rtl/config_pkg.sv
// Shared opcodes, header size and FSM state encoding
// for the ALU command sequencer.
package config_pkg;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_MUL  = 8'h88;

  localparam int HDR_BYTES = 4;

  typedef enum logic [3:0] {
    S_OPCODE,
    S_RSV,
    S_LEN_L,
    S_LEN_H,
    S_ECHO,
    S_WORD,
    S_MUL_WAIT,
    S_RESP,
    S_DRAIN
  } seq_state_e;

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte idle counter; saturates at TIMEOUT_CYCLES
// and flags expiry until cleared.
module byte_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt_q;

  assign expired_o = (cnt_q == W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Packet parser and sequencer for echo/add/multiply
// commands between UART byte streams and the ALU.
module alu_cmd_sequencer
  import config_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  output logic        mul_start_o,
  input  logic        mul_done_i,
  input  logic [31:0] mul_result_i,
  output logic        busy_o,
  output logic        err_o
);

  seq_state_e  state_q, state_d;
  logic [7:0]  op_q, len_l_q;
  logic [15:0] rem_q, len;
  logic [31:0] acc_q, word_q, full, acc_sh;
  logic [1:0]  bidx_q;
  logic        first_q, mul_start_q, err_q, err_d;
  logic        rdy, txv;
  logic [7:0]  txd;
  logic        rx_fire, tx_fire;
  logic        timing, expired, abort;

  assign len    = {rx_data_i, len_l_q};
  assign full   = {word_q[23:0], rx_data_i};
  assign acc_sh = acc_q << {bidx_q, 3'b000};

  assign timing = state_q inside {S_RSV, S_LEN_L, S_LEN_H,
                                  S_WORD, S_ECHO, S_DRAIN};
  assign abort  = expired & timing;

  byte_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (timing & ~rx_fire),
    .clear_i  (rx_fire | (state_q == S_OPCODE) | expired),
    .expired_o(expired)
  );

  // Handshake outputs; held low while reset is asserted.
  always_comb begin
    rdy = 1'b0;
    txv = 1'b0;
    txd = 8'h00;
    unique case (state_q)
      S_ECHO: begin
        rdy = tx_ready_i;
        txv = rx_valid_i;
        txd = rx_data_i;
      end
      S_RESP: begin
        txv = 1'b1;
        txd = acc_sh[31:24];
      end
      S_MUL_WAIT: ;
      default: rdy = 1'b1;
    endcase
    if (abort || rst_i) begin
      rdy = 1'b0;
      txv = 1'b0;
      txd = 8'h00;
    end
  end

  assign rx_ready_o  = rdy;
  assign tx_valid_o  = txv;
  assign tx_data_o   = txd;
  assign rx_fire     = rx_valid_i & rdy;
  assign tx_fire     = txv & tx_ready_i;
  assign mul_a_o     = acc_q;
  assign mul_b_o     = word_q;
  assign mul_start_o = mul_start_q;
  assign busy_o      = (state_q != S_OPCODE);
  assign err_o       = err_q;

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    if (abort) begin
      state_d = S_OPCODE;
      err_d   = 1'b1;
    end else begin
      unique case (state_q)
        S_OPCODE: if (rx_fire) state_d = S_RSV;
        S_RSV:    if (rx_fire) state_d = S_LEN_L;
        S_LEN_L:  if (rx_fire) state_d = S_LEN_H;
        S_LEN_H: if (rx_fire) begin
          if (len < 16'(HDR_BYTES)) begin
            state_d = S_OPCODE;
            err_d   = 1'b1;
          end else if (len == 16'(HDR_BYTES)) begin
            state_d = S_OPCODE;
          end else if (op_q == OP_ECHO) begin
            state_d = S_ECHO;
          end else if ((op_q == OP_ADD || op_q == OP_MUL)
                       && len[1:0] == 2'b00) begin
            state_d = S_WORD;
          end else begin
            state_d = S_DRAIN;
            err_d   = 1'b1;
          end
        end
        S_ECHO, S_DRAIN:
          if (rx_fire && rem_q == 16'd1) state_d = S_OPCODE;
        S_WORD: if (rx_fire && rem_q[1:0] == 2'd1) begin
          if (!first_q && op_q == OP_MUL) state_d = S_MUL_WAIT;
          else if (rem_q == 16'd1) state_d = S_RESP;
        end
        S_MUL_WAIT: if (mul_done_i)
          state_d = (rem_q == 16'd0) ? S_RESP : S_WORD;
        S_RESP: if (tx_fire && bidx_q == 2'd3) state_d = S_OPCODE;
        default: state_d = S_OPCODE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_OPCODE;
    else       state_q <= state_d;
  end

  // rem_q counts payload bytes left; its low bits mark the 4th byte of a word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q        <= '0;
      len_l_q     <= '0;
      rem_q       <= '0;
      acc_q       <= '0;
      word_q      <= '0;
      bidx_q      <= '0;
      first_q     <= 1'b0;
      mul_start_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q       <= err_d;
      mul_start_q <= 1'b0;
      unique case (state_q)
        S_OPCODE: if (rx_fire) begin
          op_q    <= rx_data_i;
          first_q <= 1'b1;
          bidx_q  <= '0;
        end
        S_LEN_L: if (rx_fire) len_l_q <= rx_data_i;
        S_LEN_H: if (rx_fire) rem_q <= len - 16'(HDR_BYTES);
        S_ECHO, S_DRAIN: if (rx_fire) rem_q <= rem_q - 16'd1;
        S_WORD: if (rx_fire) begin
          rem_q  <= rem_q - 16'd1;
          word_q <= full;
          if (rem_q[1:0] == 2'd1) begin
            first_q <= 1'b0;
            if (first_q)             acc_q <= full;
            else if (op_q == OP_ADD) acc_q <= acc_q + full;
            else                     mul_start_q <= 1'b1;
          end
        end
        S_MUL_WAIT: if (mul_done_i) acc_q <= mul_result_i;
        S_RESP: if (tx_fire) bidx_q <= bidx_q + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomized bench for alu_cmd_sequencer with a packet-level
// reference model and a single-cycle multiplier model.
module tb_alu_cmd_sequencer;

  localparam int T = 200;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic [31:0] mul_a_o, mul_b_o, mul_result_i;
  logic        mul_start_o, mul_done_i;
  logic        busy_o, err_o;

  logic rnd_q;
  logic tx_force = 1'b1;
  bit   txr_rand = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  bq_t got;
  int  err_cnt = 0;
  int  ms_cnt = 0;

  alu_cmd_sequencer #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .rx_ready_o  (rx_ready_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .mul_a_o     (mul_a_o),
    .mul_b_o     (mul_b_o),
    .mul_start_o (mul_start_o),
    .mul_done_i  (mul_done_i),
    .mul_result_i(mul_result_i),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  assign tx_ready_i = txr_rand ? rnd_q : tx_force;

  always @(posedge clk) begin
    #1;
    rnd_q = ($urandom_range(0, 3) != 0);
  end

  always @(posedge clk) begin
    if (rst_i) begin
      mul_done_i   <= 1'b0;
      mul_result_i <= 32'h0;
    end else begin
      mul_done_i <= mul_start_o;
      if (mul_start_o) mul_result_i <= mul_a_o * mul_b_o;
    end
  end

  always @(negedge clk) begin
    if (!rst_i) begin
      if (tx_valid_o && tx_ready_i) got.push_back(tx_data_o);
      if (err_o) err_cnt++;
      if (mul_start_o) ms_cnt++;
    end
  end

  // Packet-level expectation: response bytes, error pulses, multiplies.
  function automatic void model(input bq_t p, output bq_t exp,
                                output int errs, output int starts);
    logic [15:0] len;
    logic [31:0] acc, w;
    int nw;
    exp = {};
    errs = 0;
    starts = 0;
    acc = 32'h0;
    len = {p[3], p[2]};
    if (len < 4) begin
      errs = 1;
    end else if (len == 4) begin
      errs = 0;
    end else if (p[0] == 8'hEC) begin
      for (int i = 4; i < int'(len); i++) exp.push_back(p[i]);
    end else if (p[0] == 8'hAD || p[0] == 8'h88) begin
      if ((int'(len) - 4) % 4 != 0) begin
        errs = 1;
      end else begin
        nw = (int'(len) - 4) / 4;
        for (int k = 0; k < nw; k++) begin
          w = {p[4+4*k], p[5+4*k], p[6+4*k], p[7+4*k]};
          if (k == 0) acc = w;
          else if (p[0] == 8'hAD) acc = acc + w;
          else begin
            acc = acc * w;
            starts++;
          end
        end
        for (int s = 3; s >= 0; s--) exp.push_back(acc[8*s +: 8]);
      end
    end else begin
      errs = 1;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b, output bit ok);
    bit done = 1'b0;
    int n = 0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    while (!done && n < 2000) begin
      @(negedge clk);
      if (rx_ready_o) done = 1'b1;
      else n++;
    end
    if (done) begin
      @(posedge clk);
      #1;
    end
    rx_valid_i = 1'b0;
    ok = done;
  endtask

  task automatic send_all(input bq_t p, output bit ok);
    bit b_ok;
    ok = 1'b1;
    foreach (p[i]) begin
      send_byte(p[i], b_ok);
      if (!b_ok) ok = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic run_pkt(input string name, input bq_t p, input bit stall);
    bq_t exp;
    int errs, starts, gb, eb, sb, n;
    bit ok, stable;
    logic [7:0] held;
    model(p, exp, errs, starts);
    gb = got.size();
    eb = err_cnt;
    sb = ms_cnt;
    send_all(p, ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s rx_accept: byte not accepted, required all accepted", name);
    end
    if (stall) begin
      n = 0;
      while (!tx_valid_o && n < 500) begin
        @(negedge clk);
        n++;
      end
      held = tx_data_o;
      stable = tx_valid_o;
      repeat (50) begin
        @(negedge clk);
        if (!tx_valid_o || tx_data_o !== held) stable = 1'b0;
      end
      n_cmp++;
      if (!stable) begin
        n_bad++;
        $display("FAIL %s stall_hold: valid=%0b data=%h, required held %h",
                 name, tx_valid_o, tx_data_o, held);
      end
      @(posedge clk);
      #1;
      tx_force = 1'b1;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_o && n < 3000);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL %s idle: busy=%0b, required 0", name, busy_o);
    end
    n_cmp++;
    if (got.size() - gb != exp.size()) begin
      n_bad++;
      $display("FAIL %s tx_count: got %0d, required %0d",
               name, got.size() - gb, exp.size());
    end
    foreach (exp[i]) begin
      if (gb + i < got.size()) begin
        n_cmp++;
        if (got[gb+i] !== exp[i]) begin
          n_bad++;
          $display("FAIL %s tx_byte[%0d]: got %h, required %h",
                   name, i, got[gb+i], exp[i]);
        end
      end
    end
    n_cmp++;
    if (err_cnt - eb != errs) begin
      n_bad++;
      $display("FAIL %s err_pulses: got %0d, required %0d",
               name, err_cnt - eb, errs);
    end
    n_cmp++;
    if (ms_cnt - sb != starts) begin
      n_bad++;
      $display("FAIL %s mul_starts: got %0d, required %0d",
               name, ms_cnt - sb, starts);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({rx_ready_o, tx_valid_o, tx_data_o, busy_o, err_o,
         mul_start_o, mul_a_o, mul_b_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: rdy=%0b txv=%0b txd=%h busy=%0b err=%0b ms=%0b a=%h b=%h, required all 0",
               rx_ready_o, tx_valid_o, tx_data_o, busy_o, err_o,
               mul_start_o, mul_a_o, mul_b_o);
    end
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rx_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: rdy=%0b busy=%0b, required 1/0",
               rx_ready_o, busy_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_echo();
    txr_rand = 1'b1;
    run_pkt("echo", '{8'hEC, 8'h00, 8'h0C, 8'h00, 8'h42, 8'h69,
                      8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 1'b0);
  endtask

  task automatic test_add();
    txr_rand = 1'b1;
    run_pkt("add", '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00,
                     8'h01, 8'h00, 8'h00, 8'h00, 8'h02}, 1'b0);
    run_pkt("add_wrap", '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF,
                          8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h02}, 1'b0);
  endtask

  task automatic test_mul();
    txr_rand = 1'b0;
    tx_force = 1'b0;
    run_pkt("mul_stall", '{8'h88, 8'h00, 8'h10, 8'h00,
                           8'h00, 8'h00, 8'h00, 8'h03,
                           8'h00, 8'h00, 8'h00, 8'h05,
                           8'h00, 8'h00, 8'h00, 8'h02}, 1'b1);
  endtask

  task automatic test_errors();
    txr_rand = 1'b1;
    run_pkt("bad_op", '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB}, 1'b0);
    run_pkt("bad_len", '{8'hAD, 8'h00, 8'h07, 8'h00,
                         8'h11, 8'h22, 8'h33}, 1'b0);
    run_pkt("short_len", '{8'h88, 8'h00, 8'h02, 8'h00}, 1'b0);
    run_pkt("empty_pkt", '{8'h55, 8'h00, 8'h04, 8'h00}, 1'b0);
    run_pkt("echo_after", '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h5A, 8'hA5}, 1'b0);
  endtask

  task automatic test_timeout();
    int gb, eb, n;
    bit ok;
    txr_rand = 1'b0;
    tx_force = 1'b1;
    gb = got.size();
    eb = err_cnt;
    send_all('{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h00}, ok);
    n = 0;
    while (err_cnt == eb && n < T + 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_cmp++;
    if (err_cnt - eb != 1) begin
      n_bad++;
      $display("FAIL timeout_err: got %0d pulses, required 1", err_cnt - eb);
    end
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_busy: busy=%0b, required 0", busy_o);
    end
    n_cmp++;
    if (got.size() != gb) begin
      n_bad++;
      $display("FAIL timeout_tx: got %0d bytes, required 0", got.size() - gb);
    end
    @(posedge clk);
    #1;
    run_pkt("add_after_to", '{8'hAD, 8'h00, 8'h0C, 8'h00,
                              8'h12, 8'h34, 8'h56, 8'h78,
                              8'h01, 8'h01, 8'h01, 8'h01}, 1'b0);
  endtask

  task automatic test_reset_mid_resp();
    int gb, n;
    bit ok;
    txr_rand = 1'b0;
    tx_force = 1'b0;
    send_all('{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h01, 8'h00, 8'h00, 8'h00, 8'h02}, ok);
    n = 0;
    while (!tx_valid_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    gb = got.size();
    @(posedge clk);
    #1;
    tx_force = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    tx_force = 1'b0;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (got.size() - gb != 2) begin
      n_bad++;
      $display("FAIL midrst_tx_count: got %0d, required 2", got.size() - gb);
    end else begin
      n_cmp++;
      if (got[gb] !== 8'h00 || got[gb+1] !== 8'h00) begin
        n_bad++;
        $display("FAIL midrst_tx_bytes: got %h %h, required 00 00",
                 got[gb], got[gb+1]);
      end
    end
    n_cmp++;
    if ({rx_ready_o, tx_valid_o, tx_data_o, busy_o, err_o,
         mul_start_o, mul_a_o, mul_b_o} !== '0) begin
      n_bad++;
      $display("FAIL midrst_outputs: rdy=%0b txv=%0b txd=%h busy=%0b a=%h, required all 0",
               rx_ready_o, tx_valid_o, tx_data_o, busy_o, mul_a_o);
    end
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    tx_force = 1'b1;
    @(posedge clk);
    #1;
    run_pkt("echo_after_rst", '{8'hEC, 8'h00, 8'h07, 8'h00,
                                8'hDE, 8'hAD, 8'h77}, 1'b0);
  endtask

  task automatic test_random();
    bq_t p;
    int sel, len, nw;
    logic [7:0] op;
    txr_rand = 1'b1;
    for (int it = 0; it < 14; it++) begin
      sel = $urandom_range(0, 4);
      unique case (sel)
        0: begin op = 8'hEC; len = $urandom_range(5, 14); end
        1: begin op = 8'hAD; nw = $urandom_range(1, 3); len = 4 + 4 * nw; end
        2: begin op = 8'h88; nw = $urandom_range(1, 4); len = 4 + 4 * nw; end
        3: begin op = 8'(($urandom_range(0, 127))); len = $urandom_range(4, 8); end
        default: begin
          op = ($urandom_range(0, 1) != 0) ? 8'hAD : 8'h88;
          len = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 3)
                                            : 4 + 4 * $urandom_range(0, 2)
                                              + $urandom_range(1, 3);
        end
      endcase
      p = {};
      p.push_back(op);
      p.push_back(8'($urandom_range(0, 255)));
      p.push_back(8'(len));
      p.push_back(8'(len >> 8));
      for (int i = 4; i < len; i++) p.push_back(8'($urandom_range(0, 255)));
      run_pkt($sformatf("rand%0d", it), p, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_echo();
    test_add();
    test_mul();
    test_errors();
    test_timeout();
    test_reset_mid_resp();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
